// File: rtl/bus_pkg.sv
// ============================================================================
// Module   : bus_pkg
// Purpose  : Shared types and bus widths for the core memory bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;
    localparam int BUS_MW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

endpackage

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin arbiter sharing one memory bus between fetch and LSU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [BUS_AW-1:0] if_req_addr,
    output logic              if_res_valid,
    output logic [BUS_DW-1:0] if_res_data,
    output logic              if_res_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [BUS_AW-1:0] d_req_addr,
    input  logic [BUS_DW-1:0] d_req_wdata,
    input  logic [BUS_MW-1:0] d_req_mask,
    output logic              d_res_valid,
    output logic [BUS_DW-1:0] d_res_data,
    output logic              d_res_err,
    input  logic              i_bus_rd_valid,
    input  logic              i_bus_wr_valid,
    input  logic [BUS_DW-1:0] i_bus_data,
    output logic              o_bus_rd,
    output logic              o_bus_wr,
    output logic [BUS_AW-1:0] o_bus_addr,
    output logic [BUS_MW-1:0] o_bus_wrmask,
    output logic [BUS_DW-1:0] o_bus_data
);

    arb_state_t        r_state,      w_state_nxt;
    req_id_t           r_last_grant, w_last_grant_nxt;
    logic [CNT_W-1:0]  r_cnt,        w_cnt_nxt;
    logic              r_is_write,   w_is_write_nxt;

    logic              w_bus_rd_nxt, w_bus_wr_nxt;
    logic [BUS_AW-1:0] w_bus_addr_nxt;
    logic [BUS_MW-1:0] w_bus_wrmask_nxt;
    logic [BUS_DW-1:0] w_bus_data_nxt;
    logic              w_if_res_valid_nxt, w_if_res_err_nxt;
    logic [BUS_DW-1:0] w_if_res_data_nxt;
    logic              w_d_res_valid_nxt, w_d_res_err_nxt;
    logic [BUS_DW-1:0] w_d_res_data_nxt;

    logic              w_sel_if, w_sel_d, w_done, w_timeout;
    logic [BUS_DW-1:0] w_rsp_data;

    // On a tie the port that did not win last time is chosen.
    assign w_sel_if = if_req_valid && (!d_req_valid || (r_last_grant == REQ_D));
    assign w_sel_d  = d_req_valid  && (!if_req_valid || (r_last_grant == REQ_IF));

    // Gated by rst_n so ready stays low while reset is held.
    assign if_req_ready = rst_n && (r_state == IDLE) && w_sel_if;
    assign d_req_ready  = rst_n && (r_state == IDLE) && w_sel_d;

    assign w_done     = r_is_write ? i_bus_wr_valid : i_bus_rd_valid;
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1)) && !w_done;
    assign w_rsp_data = (w_done && !r_is_write) ? i_bus_data : '0;

    always_comb begin
        w_state_nxt        = r_state;
        w_last_grant_nxt   = r_last_grant;
        w_cnt_nxt          = r_cnt;
        w_is_write_nxt     = r_is_write;
        w_bus_rd_nxt       = o_bus_rd;
        w_bus_wr_nxt       = o_bus_wr;
        w_bus_addr_nxt     = o_bus_addr;
        w_bus_wrmask_nxt   = o_bus_wrmask;
        w_bus_data_nxt     = o_bus_data;
        w_if_res_valid_nxt = 1'b0;
        w_if_res_data_nxt  = '0;
        w_if_res_err_nxt   = 1'b0;
        w_d_res_valid_nxt  = 1'b0;
        w_d_res_data_nxt   = '0;
        w_d_res_err_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_sel_if) begin
                    w_state_nxt      = BUSY_IF;
                    w_last_grant_nxt = REQ_IF;
                    w_cnt_nxt        = '0;
                    w_is_write_nxt   = 1'b0;
                    w_bus_rd_nxt     = 1'b1;
                    w_bus_wr_nxt     = 1'b0;
                    w_bus_addr_nxt   = if_req_addr;
                    w_bus_wrmask_nxt = '0;
                    w_bus_data_nxt   = '0;
                end else if (w_sel_d) begin
                    w_state_nxt      = BUSY_D;
                    w_last_grant_nxt = REQ_D;
                    w_cnt_nxt        = '0;
                    w_is_write_nxt   = d_req_we;
                    w_bus_rd_nxt     = !d_req_we;
                    w_bus_wr_nxt     = d_req_we;
                    w_bus_addr_nxt   = d_req_addr;
                    w_bus_wrmask_nxt = d_req_we ? d_req_mask  : '0;
                    w_bus_data_nxt   = d_req_we ? d_req_wdata : '0;
                end
            end
            BUSY_IF, BUSY_D: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // Completion takes precedence over a simultaneous timeout.
                if (w_done || w_timeout) begin
                    w_state_nxt      = IDLE;
                    w_bus_rd_nxt     = 1'b0;
                    w_bus_wr_nxt     = 1'b0;
                    w_bus_addr_nxt   = '0;
                    w_bus_wrmask_nxt = '0;
                    w_bus_data_nxt   = '0;
                    if (r_state == BUSY_IF) begin
                        w_if_res_valid_nxt = 1'b1;
                        w_if_res_data_nxt  = w_rsp_data;
                        w_if_res_err_nxt   = !w_done;
                    end else begin
                        w_d_res_valid_nxt  = 1'b1;
                        w_d_res_data_nxt   = w_rsp_data;
                        w_d_res_err_nxt    = !w_done;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_D;
            r_cnt        <= '0;
            r_is_write   <= 1'b0;
            o_bus_rd     <= 1'b0;
            o_bus_wr     <= 1'b0;
            o_bus_addr   <= '0;
            o_bus_wrmask <= '0;
            o_bus_data   <= '0;
            if_res_valid <= 1'b0;
            if_res_data  <= '0;
            if_res_err   <= 1'b0;
            d_res_valid  <= 1'b0;
            d_res_data   <= '0;
            d_res_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_cnt        <= w_cnt_nxt;
            r_is_write   <= w_is_write_nxt;
            o_bus_rd     <= w_bus_rd_nxt;
            o_bus_wr     <= w_bus_wr_nxt;
            o_bus_addr   <= w_bus_addr_nxt;
            o_bus_wrmask <= w_bus_wrmask_nxt;
            o_bus_data   <= w_bus_data_nxt;
            if_res_valid <= w_if_res_valid_nxt;
            if_res_data  <= w_if_res_data_nxt;
            if_res_err   <= w_if_res_err_nxt;
            d_res_valid  <= w_d_res_valid_nxt;
            d_res_data   <= w_d_res_data_nxt;
            d_res_err    <= w_d_res_err_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed self-checking bench for bus_arbiter (TIMEOUT = 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_res_valid, if_res_err;
    logic [31:0] if_res_data;
    logic        d_req_valid, d_req_ready, d_req_we;
    logic [31:0] d_req_addr, d_req_wdata;
    logic [3:0]  d_req_mask;
    logic        d_res_valid, d_res_err;
    logic [31:0] d_res_data;
    logic        i_bus_rd_valid, i_bus_wr_valid;
    logic [31:0] i_bus_data;
    logic        o_bus_rd, o_bus_wr;
    logic [31:0] o_bus_addr, o_bus_data;
    logic [3:0]  o_bus_wrmask;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_res_valid(if_res_valid), .if_res_data(if_res_data), .if_res_err(if_res_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_mask(d_req_mask),
        .d_res_valid(d_res_valid), .d_res_data(d_res_data), .d_res_err(d_res_err),
        .i_bus_rd_valid(i_bus_rd_valid), .i_bus_wr_valid(i_bus_wr_valid), .i_bus_data(i_bus_data),
        .o_bus_rd(o_bus_rd), .o_bus_wr(o_bus_wr), .o_bus_addr(o_bus_addr),
        .o_bus_wrmask(o_bus_wrmask), .o_bus_data(o_bus_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        if_req_valid = 1'b0; if_req_addr = '0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0; d_req_mask = '0;
        i_bus_rd_valid = 1'b0; i_bus_wr_valid = 1'b0; i_bus_data = '0;

        // Reset state
        tick();
        check("rst_bus_rd", {31'd0, o_bus_rd}, 32'd0);
        check("rst_bus_addr", o_bus_addr, 32'd0);
        check("rst_if_res_valid", {31'd0, if_res_valid}, 32'd0);
        check("rst_d_res_valid", {31'd0, d_res_valid}, 32'd0);
        #1 rst_n = 1'b1;
        tick();

        // Fetch only, bus answers 3 cycles after o_bus_rd
        if_req_valid = 1'b1; if_req_addr = 32'h100;
        #1;
        check("f1_if_ready", {31'd0, if_req_ready}, 32'd1);
        check("f1_d_ready", {31'd0, d_req_ready}, 32'd0);
        tick();
        if_req_valid = 1'b0;
        check("f1_bus_rd", {31'd0, o_bus_rd}, 32'd1);
        check("f1_bus_addr", o_bus_addr, 32'h100);
        tick();
        tick();
        check("f1_bus_rd_held", {31'd0, o_bus_rd}, 32'd1);
        tick();
        i_bus_rd_valid = 1'b1; i_bus_data = 32'hDEADBEEF;
        check("f1_no_early_res", {31'd0, if_res_valid}, 32'd0);
        tick();
        i_bus_rd_valid = 1'b0; i_bus_data = '0;
        check("f1_if_res_valid", {31'd0, if_res_valid}, 32'd1);
        check("f1_if_res_data", if_res_data, 32'hDEADBEEF);
        check("f1_if_res_err", {31'd0, if_res_err}, 32'd0);
        check("f1_d_res_valid", {31'd0, d_res_valid}, 32'd0);
        check("f1_bus_rd_clr", {31'd0, o_bus_rd}, 32'd0);
        tick();
        check("f1_res_pulse", {31'd0, if_res_valid}, 32'd0);
        check("f1_res_data_zero", if_res_data, 32'd0);

        // Data write, ack one cycle after the bus is driven
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h2000_0004;
        d_req_wdata = 32'h1234_5678; d_req_mask = 4'b0011;
        #1;
        check("w_d_ready", {31'd0, d_req_ready}, 32'd1);
        tick();
        d_req_valid = 1'b0;
        check("w_bus_wr", {31'd0, o_bus_wr}, 32'd1);
        check("w_bus_rd", {31'd0, o_bus_rd}, 32'd0);
        check("w_bus_mask", {28'd0, o_bus_wrmask}, 32'h3);
        check("w_bus_data", o_bus_data, 32'h1234_5678);
        check("w_bus_addr", o_bus_addr, 32'h2000_0004);
        tick();
        check("w_bus_wr_held", {31'd0, o_bus_wr}, 32'd1);
        i_bus_wr_valid = 1'b1; i_bus_data = 32'hFFFF_FFFF;
        tick();
        i_bus_wr_valid = 1'b0; i_bus_data = '0;
        check("w_d_res_valid", {31'd0, d_res_valid}, 32'd1);
        check("w_d_res_data", d_res_data, 32'd0);
        check("w_d_res_err", {31'd0, d_res_err}, 32'd0);
        check("w_bus_wr_clr", {31'd0, o_bus_wr}, 32'd0);
        check("w_bus_mask_clr", {28'd0, o_bus_wrmask}, 32'd0);

        // Both ports continuously valid: grants IF, D, IF, D
        if_req_valid = 1'b1; if_req_addr = 32'h0000_0200;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h4000_0000;
        for (int i = 0; i < 4; i++) begin
            automatic logic exp_if = (i % 2 == 0);
            #1;
            check($sformatf("rr%0d_if_ready", i), {31'd0, if_req_ready}, {31'd0, exp_if});
            check($sformatf("rr%0d_d_ready", i), {31'd0, d_req_ready}, {31'd0, !exp_if});
            tick();
            check($sformatf("rr%0d_busy_if_ready", i), {31'd0, if_req_ready}, 32'd0);
            check($sformatf("rr%0d_busy_d_ready", i), {31'd0, d_req_ready}, 32'd0);
            check($sformatf("rr%0d_bus_addr", i), o_bus_addr, exp_if ? 32'h0000_0200 : 32'h4000_0000);
            i_bus_rd_valid = 1'b1; i_bus_data = 32'hA0 + 32'(i);
            tick();
            i_bus_rd_valid = 1'b0; i_bus_data = '0;
            if (i == 3) begin
                if_req_valid = 1'b0; d_req_valid = 1'b0;
            end
            check($sformatf("rr%0d_if_res", i), {31'd0, if_res_valid}, {31'd0, exp_if});
            check($sformatf("rr%0d_d_res", i), {31'd0, d_res_valid}, {31'd0, !exp_if});
            check($sformatf("rr%0d_res_data", i), exp_if ? if_res_data : d_res_data, 32'hA0 + 32'(i));
        end
        tick();

        // Data read with no bus response: timeout after 8 busy cycles
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h3000_0000;
        i_bus_data = 32'h5555_5555;
        #1;
        check("to_d_ready", {31'd0, d_req_ready}, 32'd1);
        tick();
        d_req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("to_held%0d", k), {31'd0, o_bus_rd}, 32'd1);
            check($sformatf("to_nores%0d", k), {31'd0, d_res_valid}, 32'd0);
            tick();
        end
        check("to_d_res_valid", {31'd0, d_res_valid}, 32'd1);
        check("to_d_res_err", {31'd0, d_res_err}, 32'd1);
        check("to_d_res_data", d_res_data, 32'd0);
        check("to_bus_rd_clr", {31'd0, o_bus_rd}, 32'd0);
        tick();
        i_bus_data = '0;
        check("to_err_pulse", {31'd0, d_res_err}, 32'd0);

        // Fetch sees the wrong strobe, then completes normally
        if_req_valid = 1'b1; if_req_addr = 32'h400;
        tick();
        if_req_valid = 1'b0;
        i_bus_wr_valid = 1'b1;
        tick();
        i_bus_wr_valid = 1'b0;
        check("ws_no_res", {31'd0, if_res_valid}, 32'd0);
        check("ws_bus_held", {31'd0, o_bus_rd}, 32'd1);
        check("ws_addr_held", o_bus_addr, 32'h400);
        tick();
        i_bus_rd_valid = 1'b1; i_bus_data = 32'hCAFEF00D;
        tick();
        i_bus_rd_valid = 1'b0; i_bus_data = '0;
        check("ws_if_res_valid", {31'd0, if_res_valid}, 32'd1);
        check("ws_if_res_data", if_res_data, 32'hCAFEF00D);
        check("ws_if_res_err", {31'd0, if_res_err}, 32'd0);

        // Completion in the last counted cycle beats the timeout
        if_req_valid = 1'b1; if_req_addr = 32'h500;
        tick();
        if_req_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("edge_no_res", {31'd0, if_res_valid}, 32'd0);
        i_bus_rd_valid = 1'b1; i_bus_data = 32'h0BADF00D;
        tick();
        i_bus_rd_valid = 1'b0; i_bus_data = '0;
        check("edge_res_valid", {31'd0, if_res_valid}, 32'd1);
        check("edge_res_err", {31'd0, if_res_err}, 32'd0);
        check("edge_res_data", if_res_data, 32'h0BADF00D);

        // Reset two cycles into a pending data read
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h6000_0000;
        tick();
        d_req_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("ar_bus_rd", {31'd0, o_bus_rd}, 32'd0);
        check("ar_bus_addr", o_bus_addr, 32'd0);
        if_req_valid = 1'b1; d_req_valid = 1'b1; if_req_addr = 32'h700;
        #1;
        check("ar_if_ready", {31'd0, if_req_ready}, 32'd0);
        check("ar_d_ready", {31'd0, d_req_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("ar_rel_if_ready", {31'd0, if_req_ready}, 32'd1);
        check("ar_rel_d_ready", {31'd0, d_req_ready}, 32'd0);
        tick();
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        check("ar_no_d_res", {31'd0, d_res_valid}, 32'd0);
        check("ar_grant_if_addr", o_bus_addr, 32'h700);
        check("ar_grant_if_rd", {31'd0, o_bus_rd}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
